// File: rtl/rv_regfile_pkg.sv
// rv_regfile_pkg -- shared types and default sizes for the multi-port register file.
// The read/write collision policy is chosen by the RV_REGFILE_BYPASS_EN macro
// (defined: write-first bypass, undefined: read-first).
package rv_regfile_pkg;

    // Default geometry of the register file
    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;
    localparam int RF_NRD_DEF   = 2;
    localparam int RF_NWR_DEF   = 1;

    // Initialisation FSM: CLEAR zeroes entries one per cycle, READY is absorbing
    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rv_regfile_rdport.sv
// rv_regfile_rdport -- one registered read port of the register file.
// Selects the addressed entry, forces x0 and not-yet-initialised reads to zero,
// and with RV_REGFILE_BYPASS_EN defined forwards same-edge write data
// (highest write port wins) so the read sees the new value.
module rv_regfile_rdport
    import rv_regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NWR   = RF_NWR_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_ready,
    input  logic                           i_rd_en,
    input  logic [AW-1:0]                  i_rs,
    input  logic [NREGS-1:0][XLEN-1:0]     i_mem,
`ifdef RV_REGFILE_BYPASS_EN
    input  logic [NWR-1:0]                 i_we_eff,
    input  logic [NWR-1:0][AW-1:0]         i_wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]       i_wr_data,
`endif
    output logic [XLEN-1:0]                o_rdata
);

    logic [XLEN-1:0] rdata_nxt;

    // Next read value: stored entry, optionally overridden by a same-edge write, x0/CLEAR masked last
    always_comb begin
        rdata_nxt = i_mem[i_rs];
`ifdef RV_REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
            if (i_we_eff[w] && (i_wr_addr[w] == i_rs))
                rdata_nxt = i_wr_data[w];
        end
`endif
        if ((i_rs == '0) || !i_ready)
            rdata_nxt = '0;
    end

    // Output register: cleared by reset, loaded on enable, held otherwise
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            o_rdata <= '0;
        else if (i_rd_en)
            o_rdata <= rdata_nxt;
    end

endmodule

// File: rtl/rv_regfile_mp.sv
// rv_regfile_mp -- multi-port RISC-V style register file with hardwired x0.
// After reset a CLEAR sweep zeroes entries 1..NREGS-1, one per cycle; external
// writes are ignored and reads return 0 until o_ready rises.
// Collision policy: RV_REGFILE_BYPASS_EN defined -> write-first, else read-first.
module rv_regfile_mp
    import rv_regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NRD   = RF_NRD_DEF,
    parameter int NWR   = RF_NWR_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [NRD-1:0]                 i_rd_en,
    input  logic [NRD-1:0][AW-1:0]         i_rs,
    output logic [NRD-1:0][XLEN-1:0]       o_rdata,
    input  logic [NWR-1:0]                 i_we,
    input  logic [NWR-1:0][AW-1:0]         i_rd,
    input  logic [NWR-1:0][XLEN-1:0]       i_wdata,
    output logic                           o_ready
);

    rf_state_t                    state;
    logic [AW-1:0]                clr_cnt;
    logic [NREGS-1:0][XLEN-1:0]   mem;
    logic [NWR-1:0]               we_eff;

    assign o_ready = (state == RF_READY);

    // A write only lands when initialised and not aimed at x0
    always_comb begin
        for (int w = 0; w < NWR; w++)
            we_eff[w] = i_we[w] && o_ready && (i_rd[w] != '0);
    end

    // Init FSM: reset restarts the sweep at entry 1; leave CLEAR on the edge zeroing the last entry
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= RF_CLEAR;
            clr_cnt <= AW'(1);
        end else if (state == RF_CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == AW'(NREGS - 1))
                state <= RF_READY;
        end
    end

    // Storage: no reset on contents; CLEAR zeroes one entry, else writes in port order so the higher port wins
    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            if (state == RF_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                for (int w = 0; w < NWR; w++) begin
                    if (we_eff[w])
                        mem[i_rd[w]] <= i_wdata[w];
                end
            end
        end
    end

    // One registered read port per NRD
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        rv_regfile_rdport #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .NWR   (NWR)
        ) u_rdport (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_ready   (o_ready),
            .i_rd_en   (i_rd_en[p]),
            .i_rs      (i_rs[p]),
            .i_mem     (mem),
`ifdef RV_REGFILE_BYPASS_EN
            .i_we_eff  (we_eff),
            .i_wr_addr (i_rd),
            .i_wr_data (i_wdata),
`endif
            .o_rdata   (o_rdata[p])
        );
    end

endmodule

// File: tb/tb_rv_regfile_mp.sv
// tb_rv_regfile_mp -- self-checking bench for rv_regfile_mp (NRD=2, NWR=2).
// Directed scenarios plus a randomized run against an array-based reference model.
module tb_rv_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic [1:0]        i_rd_en;
    logic [1:0][4:0]   i_rs;
    logic [1:0][31:0]  o_rdata;
    logic [1:0]        i_we;
    logic [1:0][4:0]   i_rd;
    logic [1:0][31:0]  i_wdata;
    logic              o_ready;

    int n_pass = 0;
    int n_total = 0;

`ifdef RV_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    rv_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_rd_en   (i_rd_en),
        .i_rs      (i_rs),
        .o_rdata   (o_rdata),
        .i_we      (i_we),
        .i_rd      (i_rd),
        .i_wdata   (i_wdata),
        .o_ready   (o_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_rd_en = '0; i_rs = '0; i_we = '0; i_rd = '0; i_wdata = '0;
    endtask

    // Counts cycles with o_ready low, starting from an already-counted 'start'
    task automatic wait_ready(input int start, output int n);
        n = start;
        while (o_ready !== 1'b1 && n < 100) begin
            n++;
            cyc();
        end
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        idle();
        i_we[port] = 1'b1; i_rd[port] = a; i_wdata[port] = d;
        cyc();
        idle();
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
        idle();
        i_rd_en = 2'b11; i_rs[0] = a0; i_rs[1] = a1;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        int n;
        idle();
        i_reset_n = 1'b0;
        cyc(); cyc();
        n_total++;
        if (o_ready !== 1'b0) $display("FAIL reset_ready got %0b want 0", o_ready); else n_pass++;
        n_total++;
        if (o_rdata !== '0) $display("FAIL reset_rdata got %h want 0", o_rdata); else n_pass++;
        i_reset_n = 1'b1;
        wait_ready(0, n);
        n_total++;
        if (n !== 31) $display("FAIL clear_len got %0d want 31", n); else n_pass++;
        for (int a = 1; a < NREGS; a += 2) begin
            rd2(5'(a), 5'(a + 1 < NREGS ? a + 1 : 1));
            n_total++;
            if (o_rdata !== '0) $display("FAIL clear_read x%0d got %h want 0", a, o_rdata); else n_pass++;
        end
    endtask

    task automatic test_write_read();
        wr(0, 5'd5, 32'hDEADBEEF);
        rd2(5'd5, 5'd5);
        n_total++;
        if (o_rdata[0] !== 32'hDEADBEEF || o_rdata[1] !== 32'hDEADBEEF)
            $display("FAIL rw_x5 got %h want deadbeef x2", o_rdata); else n_pass++;
        // read enables low with a different address: outputs hold
        idle();
        i_rs[0] = 5'd1; i_rs[1] = 5'd2;
        cyc(); cyc();
        n_total++;
        if (o_rdata[0] !== 32'hDEADBEEF || o_rdata[1] !== 32'hDEADBEEF)
            $display("FAIL hold got %h want deadbeef x2", o_rdata); else n_pass++;
    endtask

    task automatic test_x0();
        wr(1, 5'd0, 32'h12345678);
        rd2(5'd0, 5'd5);
        n_total++;
        if (o_rdata[0] !== 32'h0) $display("FAIL x0_read got %h want 0", o_rdata[0]); else n_pass++;
        // same-edge write+read of x0 must also give 0, bypass or not
        idle();
        i_we[0] = 1'b1; i_rd[0] = 5'd0; i_wdata[0] = 32'hFFFFFFFF;
        i_rd_en[0] = 1'b1; i_rs[0] = 5'd0;
        cyc(); idle();
        n_total++;
        if (o_rdata[0] !== 32'h0) $display("FAIL x0_bypass got %h want 0", o_rdata[0]); else n_pass++;
    endtask

    task automatic test_collision();
        logic [31:0] exp;
        wr(0, 5'd7, 32'h11111111);
        idle();
        i_we[0] = 1'b1; i_rd[0] = 5'd7; i_wdata[0] = 32'hA5A5A5A5;
        i_rd_en[0] = 1'b1; i_rs[0] = 5'd7;
        cyc(); idle();
        exp = BYPASS ? 32'hA5A5A5A5 : 32'h11111111;
        n_total++;
        if (o_rdata[0] !== exp) $display("FAIL collide_x7 got %h want %h", o_rdata[0], exp); else n_pass++;
        rd2(5'd7, 5'd7);
        n_total++;
        if (o_rdata[1] !== 32'hA5A5A5A5) $display("FAIL after_x7 got %h want a5a5a5a5", o_rdata[1]); else n_pass++;
    endtask

    task automatic test_dual_write();
        logic [31:0] exp;
        idle();
        i_we = 2'b11; i_rd[0] = 5'd3; i_rd[1] = 5'd3;
        i_wdata[0] = 32'h1; i_wdata[1] = 32'h2;
        i_rd_en[1] = 1'b1; i_rs[1] = 5'd3;
        cyc(); idle();
        exp = BYPASS ? 32'h2 : 32'h0;
        n_total++;
        if (o_rdata[1] !== exp) $display("FAIL dual_same_edge got %h want %h", o_rdata[1], exp); else n_pass++;
        rd2(5'd3, 5'd3);
        n_total++;
        if (o_rdata[0] !== 32'h2) $display("FAIL dual_x3 got %h want 2", o_rdata[0]); else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        wr(0, 5'd20, 32'h20202020);
        rd2(5'd20, 5'd5);
        i_reset_n = 1'b0;
        cyc();
        i_reset_n = 1'b1;
        n_total++;
        if (o_rdata !== '0 || o_ready !== 1'b0)
            $display("FAIL rst_op got rdata=%h ready=%0b want 0/0", o_rdata, o_ready); else n_pass++;
        // counter goes 1 -> 10 over nine edges
        for (int k = 0; k < 9; k++) cyc();
        i_reset_n = 1'b0;
        cyc();
        i_reset_n = 1'b1;
        n = 0;
        while (o_ready !== 1'b1 && n < 100) begin
            n++;
            idle();
            if (n == 15) begin
                i_we[1] = 1'b1; i_rd[1] = 5'd5; i_wdata[1] = 32'hCAFEF00D;
                i_rd_en[0] = 1'b1; i_rs[0] = 5'd20;
            end
            cyc();
            if (n == 15) begin
                n_total++;
                if (o_rdata[0] !== 32'h0) $display("FAIL clear_stale_read got %h want 0", o_rdata[0]); else n_pass++;
            end
        end
        idle();
        n_total++;
        if (n !== 31) $display("FAIL mid_clear_len got %0d want 31", n); else n_pass++;
        rd2(5'd5, 5'd20);
        n_total++;
        if (o_rdata !== '0) $display("FAIL clear_write_dropped got %h want 0", o_rdata); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] model [NREGS];
        logic [31:0] exp [2];
        int n;
        int errs;
        i_reset_n = 1'b0;
        idle();
        cyc();
        i_reset_n = 1'b1;
        wait_ready(0, n);
        for (int a = 0; a < NREGS; a++) model[a] = '0;
        exp[0] = '0; exp[1] = '0;
        errs = 0;
        for (int t = 0; t < 400; t++) begin
            for (int p = 0; p < 2; p++) begin
                i_rd_en[p] = 1'($urandom_range(0, 3) != 0);
                i_rs[p]    = 5'($urandom_range(0, 7));
                i_we[p]    = 1'($urandom_range(0, 1));
                i_rd[p]    = 5'($urandom_range(0, 7));
                i_wdata[p] = $urandom;
            end
            for (int p = 0; p < 2; p++) begin
                if (i_rd_en[p]) begin
                    exp[p] = (i_rs[p] == 0) ? 32'h0 : model[i_rs[p]];
                    if (BYPASS && i_rs[p] != 0) begin
                        for (int w = 0; w < 2; w++)
                            if (i_we[w] && i_rd[w] == i_rs[p]) exp[p] = i_wdata[w];
                    end
                end
            end
            for (int w = 0; w < 2; w++)
                if (i_we[w] && i_rd[w] != 0) model[i_rd[w]] = i_wdata[w];
            cyc();
            for (int p = 0; p < 2; p++) begin
                n_total++;
                if (o_rdata[p] !== exp[p]) begin
                    if (errs < 10)
                        $display("FAIL rand t=%0d port%0d got %h want %h", t, p, o_rdata[p], exp[p]);
                    errs++;
                end else n_pass++;
            end
        end
        idle();
    endtask

    initial begin
        idle();
        i_reset_n = 1'b1;
        test_reset();
        test_write_read();
        test_x0();
        test_collision();
        test_dual_write();
        test_reset_mid_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv_regfile_mp.md
RV_REGFILE_MP -- requirements
Module: rv_regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, >= 4.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 1, number of write ports (1..2).
REQ-005 SHALL derive AW = $clog2(NREGS) as a localparam.
REQ-006 i_clk  in  1  clock; all state updates on rising edge.
REQ-007 i_reset_n  in  1  reset, synchronous, active-low.
REQ-008 i_rd_en  in  [NRD]  per-port read enable.
REQ-009 i_rs  in  [NRD][AW]  per-port read address.
REQ-010 o_rdata  out  [NRD][XLEN]  per-port registered read data.
REQ-011 i_we  in  [NWR]  per-port write enable.
REQ-012 i_rd  in  [NWR][AW]  per-port write address.
REQ-013 i_wdata  in  [NWR][XLEN]  per-port write data.
REQ-014 o_ready  out  1  high when the file is initialised and accepts writes.

Function
REQ-015 Entry 0 SHALL be hardwired zero: writes to address 0 are discarded, and reads of address 0 return 0 on every path, including bypass.
REQ-016 Read latency SHALL be one cycle: o_rdata[p] updates on the edge where i_rd_en[p]=1 and holds its value while i_rd_en[p]=0.
REQ-017 A write with i_we[w]=1, o_ready=1 and i_rd[w]!=0 SHALL update the entry on that edge.
REQ-018 Two write ports addressing the same entry on the same edge SHALL resolve so that the higher port index wins.
REQ-019 A two-state FSM SHALL control initialisation: CLEAR (counter-driven zeroing) and READY.
REQ-020 In CLEAR, one entry SHALL be zeroed per cycle, addresses 1..NREGS-1 ascending, using an AW-bit counter.
REQ-021 CLEAR->READY SHALL occur on the edge that zeroes entry NREGS-1; o_ready SHALL rise on that edge, giving NREGS-1 cycles of o_ready=0 after reset release.
REQ-022 External writes SHALL be ignored while o_ready=0.
REQ-023 Reads during CLEAR SHALL return 0.
REQ-024 READY SHALL be absorbing; only reset returns the FSM to CLEAR.
REQ-025 Reset asserted mid-CLEAR or mid-operation SHALL restart CLEAR from address 1.

Reset
REQ-026 On an edge with i_reset_n=0, the block SHALL: set FSM=CLEAR, counter=1, o_ready=0, all o_rdata=0.
REQ-027 Register contents SHALL not be altered by reset itself; zeroing is performed only by CLEAR.

Configuration
REQ-028 Macro RV_REGFILE_BYPASS_EN SHALL select the read/write collision policy.
REQ-029 With RV_REGFILE_BYPASS_EN defined: a read of an address written on the same edge SHALL return the new data (write-first), applying port priority per REQ-018.
REQ-030 With RV_REGFILE_BYPASS_EN undefined: such a read SHALL return the old data (read-first), and the bypass multiplexers SHALL not be generated.

Structure
REQ-031 Package rv_regfile_pkg SHALL hold the FSM state enum (RF_CLEAR, RF_READY) and the default-parameter constants.
REQ-032 Sub-module rv_regfile_rdport SHALL implement one read port (address decode, x0 masking, optional bypass, output register), instantiated NRD times via generate.

Verification
REQ-033 Release reset with NREGS=32 -> o_ready=0 for exactly 31 cycles, then 1; reads of addresses 1..31 return 0.
REQ-034 Write 0xDEADBEEF to x5, then read x5 on ports 0 and 1 -> both return 0xDEADBEEF one cycle later.
REQ-035 Write 0x12345678 to x0, then read x0 -> returns 0x00000000.
REQ-036 Same-edge write of 0xA5A5A5A5 to x7 and read of x7 -> returns 0xA5A5A5A5 with BYPASS_EN, the prior value without it.
REQ-037 NWR=2, both ports write x3 (0x1 on port 0, 0x2 on port 1) -> a later read of x3 returns 0x2.
REQ-038 Assert reset at CLEAR counter=10, then release -> o_ready=0 for a further 31 cycles; a write attempted during CLEAR leaves the target entry at 0.
